// File: rtl/ipr_read_streamer.sv
// ipr_read_streamer: fetches BULK_NUMBER words from a fixed IPR DATA register
// and forwards them on a valid/ready stream through a 2-entry buffer.
// Ports:
//   r_clk, r_rst_n             clock, synchronous active-low reset
//   start, abort               single-cycle control pulses
//   ipr_req/we/addr            read request side (we tied 0, addr = BASE_ADDR)
//   ipr_gnt/rvalid/rdata       slave grant (same cycle) and response (next cycle)
//   m_valid/m_ready/m_data     output stream
//   busy, done, timeout        status: not idle, end-of-bulk pulse, sticky watchdog
//   word_cnt                   words captured in the current or last fetch
module ipr_read_streamer #(
    parameter int unsigned DSIZE          = 32,
    parameter int unsigned BULK_NUMBER    = 10,
    parameter int unsigned WATCHDOG_LIMIT = 100,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic             r_clk,
    input  logic             r_rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             ipr_req,
    output logic             ipr_we,
    output logic [31:0]      ipr_addr,
    input  logic             ipr_gnt,
    input  logic             ipr_rvalid,
    input  logic [DSIZE-1:0] ipr_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [7:0]       word_cnt
);

    localparam int unsigned WD_W  = 16;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WD_W-1:0]    r_wd;
    logic [WD_W-1:0]    w_wd_plus;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_done;
    logic               r_timeout;
    logic               r_abort_pend;

    logic [DSIZE-1:0]   r_mem [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;

    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_start_fetch;
    logic               w_wd_clr;
    logic               w_wd_inc;
    logic               w_set_timeout;
    logic               w_set_done;
    logic               w_abort_pend_set;

    assign w_wd_plus = r_wd + WD_W'(1);
    assign w_pop     = (r_count != 2'd0) && m_ready;

    // State register
    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_nxt      = r_state;
        w_req            = 1'b0;
        w_push           = 1'b0;
        w_start_fetch    = 1'b0;
        w_wd_clr         = 1'b0;
        w_wd_inc         = 1'b0;
        w_set_timeout    = 1'b0;
        w_set_done       = 1'b0;
        w_abort_pend_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_fetch = 1'b1;
                    w_state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Abort withdraws the request in the same cycle and beats the watchdog.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count < 2'd2) begin
                    w_req = 1'b1;
                    if (ipr_gnt) begin
                        w_wd_clr    = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_wd_inc = 1'b1;
                        if (w_wd_plus == WD_W'(WATCHDOG_LIMIT)) begin
                            w_set_timeout = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (ipr_rvalid) begin
                    w_push = 1'b1;
                    if (abort || r_abort_pend) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_word_cnt + CNT_W'(1) == CNT_W'(BULK_NUMBER)) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end else if (abort) begin
                    // Response still owed by the slave: remember the abort until it lands.
                    w_abort_pend_set = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, status flags and buffer pointers
    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            r_wd         <= '0;
            r_word_cnt   <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_count      <= 2'd0;
        end else begin
            r_done <= w_set_done;

            if (w_start_fetch || w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= w_wd_plus;
            end

            if (w_start_fetch) begin
                r_word_cnt <= '0;
            end else if (w_push) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end

            if (w_start_fetch) begin
                r_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end

            if (w_start_fetch || w_push) begin
                r_abort_pend <= 1'b0;
            end else if (w_abort_pend_set) begin
                r_abort_pend <= 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage; contents are don't-care while the entry is empty
    always_ff @(posedge r_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ipr_rdata;
        end
    end

    assign ipr_req  = w_req;
    assign ipr_we   = 1'b0;
    assign ipr_addr = BASE_ADDR;
    assign m_valid  = (r_count != 2'd0);
    assign m_data   = r_mem[r_rd_ptr];
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign timeout  = r_timeout;
    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_ipr_read_streamer.sv
// Directed bench for ipr_read_streamer with a scoreboard on the output stream.
module tb_ipr_read_streamer;

    localparam int unsigned DSIZE = 32;
    localparam int unsigned BULK  = 4;
    localparam int unsigned WDL   = 5;
    localparam logic [31:0] BASE  = 32'h4000_0010;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             ipr_req;
    logic             ipr_we;
    logic [31:0]      ipr_addr;
    logic             ipr_gnt;
    logic             ipr_rvalid;
    logic [DSIZE-1:0] ipr_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [7:0]       word_cnt;

    // Slave model controls
    logic             slv_en;
    logic             slv_clear;
    logic             slv_rvalid;
    logic [DSIZE-1:0] slv_rdata;
    logic             spur_rv;
    int               g_cnt = 0;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               done_cnt = 0;
    logic             chk_spacing;
    bit               have_prev = 1'b0;
    int               prev_cyc  = 0;
    logic [DSIZE-1:0] sb [$];

    ipr_read_streamer #(
        .DSIZE          (DSIZE),
        .BULK_NUMBER    (BULK),
        .WATCHDOG_LIMIT (WDL),
        .BASE_ADDR      (BASE)
    ) dut (
        .r_clk      (clk),
        .r_rst_n    (rst_n),
        .start      (start),
        .abort      (abort),
        .ipr_req    (ipr_req),
        .ipr_we     (ipr_we),
        .ipr_addr   (ipr_addr),
        .ipr_gnt    (ipr_gnt),
        .ipr_rvalid (ipr_rvalid),
        .ipr_rdata  (ipr_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: grants combinationally, answers 0x11, 0x22, ... one cycle later
    assign ipr_gnt    = ipr_req & slv_en;
    assign ipr_rvalid = slv_rvalid | spur_rv;
    assign ipr_rdata  = spur_rv ? 32'hDEAD_BEEF : slv_rdata;

    always @(posedge clk) begin
        if (slv_clear) begin
            slv_rvalid <= 1'b0;
            slv_rdata  <= '0;
            g_cnt      <= 0;
        end else begin
            slv_rvalid <= ipr_req & ipr_gnt;
            if (ipr_req && ipr_gnt) begin
                slv_rdata <= DSIZE'((g_cnt + 1) * 32'h11);
                g_cnt     <= g_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every accepted word against the scoreboard
    always @(negedge clk) begin
        logic [63:0] exp;
        if (done) done_cnt++;
        if (m_valid && m_ready) begin
            exp = 'x;
            if (sb.size() > 0) exp = 64'(sb.pop_front());
            check("sb_word", 64'(m_data), exp);
            if (chk_spacing) begin
                if (have_prev) check("spacing", 64'(cyc - prev_cyc), 64'd2);
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end
        end
        if (!chk_spacing) have_prev = 1'b0;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_slave();
        slv_clear = 1'b1;
        @(negedge clk);
        slv_clear = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic push_words(input int n);
        for (int i = 1; i <= n; i++) sb.push_back(DSIZE'(i * 32'h11));
    endtask

    initial begin
        int d0;
        int req_cyc;
        int k;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        slv_en = 1'b0; slv_clear = 1'b1; spur_rv = 1'b0; chk_spacing = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",     64'(ipr_req),  64'd0);
        check("rst_mvalid",  64'(m_valid),  64'd0);
        check("rst_busy",    64'(busy),     64'd0);
        check("rst_done",    64'(done),     64'd0);
        check("rst_timeout", 64'(timeout),  64'd0);
        check("rst_wcnt",    64'(word_cnt), 64'd0);
        check("rst_we",      64'(ipr_we),   64'd0);
        check("rst_addr",    64'(ipr_addr), 64'(BASE));
        rst_n = 1'b1;
        slv_clear = 1'b0;
        @(negedge clk);

        // Full bulk fetch with free-flowing output
        clear_slave();
        slv_en = 1'b1; m_ready = 1'b1;
        push_words(4);
        d0 = done_cnt;
        chk_spacing = 1'b1;
        pulse_start();
        wait_idle(40, "s1_idle");
        repeat (4) @(negedge clk);
        chk_spacing = 1'b0;
        check("s1_drained", 64'(sb.size()),     64'd0);
        check("s1_done",    64'(done_cnt - d0), 64'd1);
        check("s1_wcnt",    64'(word_cnt),      64'd4);
        check("s1_timeout", 64'(timeout),       64'd0);
        check("s1_we",      64'(ipr_we),        64'd0);

        // Backpressure: buffer fills to 2, requests stop, watchdog frozen
        m_ready = 1'b0;
        clear_slave();
        push_words(4);
        d0 = done_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        check("s2_mvalid",  64'(m_valid),  64'd1);
        check("s2_wcnt",    64'(word_cnt), 64'd2);
        check("s2_req",     64'(ipr_req),  64'd0);
        check("s2_busy",    64'(busy),     64'd1);
        check("s2_timeout", 64'(timeout),  64'd0);
        check("s2_head",    64'(m_data),   64'h11);
        m_ready = 1'b1;
        wait_idle(40, "s2_idle");
        repeat (4) @(negedge clk);
        check("s2_drained", 64'(sb.size()),     64'd0);
        check("s2_done",    64'(done_cnt - d0), 64'd1);
        check("s2_wcnt4",   64'(word_cnt),      64'd4);

        // Slave never grants: watchdog expires after WDL request cycles
        slv_en = 1'b0;
        d0 = done_cnt;
        pulse_start();
        req_cyc = 0; k = 0;
        while (busy && k < 30) begin
            if (ipr_req) req_cyc++;
            @(negedge clk);
            k++;
        end
        check("s3_idle",    64'(busy),          64'd0);
        check("s3_reqcyc",  64'(req_cyc),       64'(WDL));
        check("s3_timeout", 64'(timeout),       64'd1);
        check("s3_done",    64'(done_cnt - d0), 64'd0);
        check("s3_wcnt",    64'(word_cnt),      64'd0);

        // Abort during the WAIT cycle of word 2
        slv_en = 1'b1;
        clear_slave();
        push_words(2);
        d0 = done_cnt;
        pulse_start();
        check("s4_timeout_clr", 64'(timeout), 64'd0);
        k = 0;
        while (!(busy && !ipr_req && word_cnt == 8'd1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("s4_in_wait2", 64'(busy && !ipr_req && word_cnt == 8'd1), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s4_busy", 64'(busy),     64'd0);
        check("s4_wcnt", 64'(word_cnt), 64'd2);
        repeat (4) @(negedge clk);
        check("s4_drained", 64'(sb.size()),     64'd0);
        check("s4_done",    64'(done_cnt - d0), 64'd0);
        check("s4_req",     64'(ipr_req),       64'd0);
        check("s4_wcnt2",   64'(word_cnt),      64'd2);

        // Reset while the buffer holds 2 words
        m_ready = 1'b0;
        clear_slave();
        push_words(4);
        pulse_start();
        k = 0;
        while (!(word_cnt == 8'd2 && !ipr_req) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("s5_full", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("s5_mvalid", 64'(m_valid),  64'd0);
        check("s5_req",    64'(ipr_req),  64'd0);
        check("s5_wcnt",   64'(word_cnt), 64'd0);
        check("s5_busy",   64'(busy),     64'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("s5_post_mvalid", 64'(m_valid), 64'd0);

        // Spurious rvalid in IDLE, then start and rvalid while busy in ISSUE
        slv_en = 1'b0;
        spur_rv = 1'b1;
        @(negedge clk);
        spur_rv = 1'b0;
        check("s6_idle_mvalid", 64'(m_valid),  64'd0);
        check("s6_idle_wcnt",   64'(word_cnt), 64'd0);
        check("s6_idle_busy",   64'(busy),     64'd0);
        pulse_start();
        req_cyc = 0; k = 0;
        while (busy && k < 30) begin
            if (ipr_req) req_cyc++;
            if (k == 1) begin
                start = 1'b1; spur_rv = 1'b1;
            end else begin
                start = 1'b0; spur_rv = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0; spur_rv = 1'b0;
        check("s6_reqcyc",  64'(req_cyc),  64'(WDL));
        check("s6_timeout", 64'(timeout),  64'd1);
        check("s6_wcnt",    64'(word_cnt), 64'd0);
        check("s6_mvalid",  64'(m_valid),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
